obi_data_arbiter: RTL
=====================

Name: obi_data_arbiter

Overview:
- Shares the single OBI data port to memory between two requesters: the scalar core LSU (port 0) and the vector LSU (port 1).
- Arbitrates round-robin and holds the selection stable until memory grants, as OBI requires.
- Tracks outstanding transactions in order, so each rvalid/rdata returns to the requester that issued it.
- Sits between the core/vector LSU masters and the top-level data bus.

Parameters:
- MAX_OUT, 2, maximum outstanding (granted, not yet responded) transactions; power of two, >= 1.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- core_req_i  in  1  core OBI request
- core_gnt_o  out  1  core grant
- core_rvalid_o  out  1  core response valid
- core_addr_i  in  ADDR_W  core address
- core_we_i  in  1  core write enable
- core_be_i  in  4  core byte enables
- core_wdata_i  in  32  core write data
- core_rdata_o  out  32  core read data
- vlsu_req_i, vlsu_gnt_o, vlsu_rvalid_o, vlsu_addr_i, vlsu_we_i, vlsu_be_i, vlsu_wdata_i, vlsu_rdata_o  (same directions and widths as core)  vector LSU port
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_rvalid_i  in  1  memory response valid
- data_addr_o  out  ADDR_W  memory address
- data_we_o  out  1  memory write enable
- data_be_o  out  4  memory byte enables
- data_wdata_o  out  32  memory write data
- data_rdata_i  in  32  memory read data
- outstanding_o  out  $clog2(MAX_OUT)+1  count of outstanding transactions
- err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Reset values:
  - All gnt/rvalid outputs, data_req_o, data_we_o, outstanding_o and err_o are 0.
  - data_addr_o, data_be_o and data_wdata_o are 0.
  - last_grant = VLSU, so core wins the first tie.
  - Hold state = ARB_FREE; ID FIFO is empty.
- Arbitration FSM, states ARB_FREE and ARB_HOLD:
  - ARB_FREE:
    - sel = the single requester, if only one requests.
    - If both request, sel = the requester that is not last_grant.
    - data_req_o = the selected req and not fifo_full.
    - On data_gnt_i: set last_grant = sel; stay ARB_FREE.
    - On data_req_o && !data_gnt_i: latch sel into hold_id; go to ARB_HOLD.
  - ARB_HOLD:
    - sel = hold_id regardless of the other request.
    - data_req_o = hold_id's req.
    - On data_gnt_i: update last_grant; go to ARB_FREE.
    - If hold_id deasserts req (protocol violation), return to ARB_FREE without a grant.
- Muxing is combinational, zero added latency:
  - data_addr/we/be/wdata = the selected requester's fields.
  - When data_req_o = 0, drive 0.
  - The grant goes only to sel: x_gnt_o = data_gnt_i && data_req_o && (sel == x).
- The non-selected requester sees gnt = 0 and must keep its request asserted.
- ID FIFO:
  - Push sel on data_req_o && data_gnt_i.
  - Pop on data_rvalid_i.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - fifo_full (count == MAX_OUT) forces data_req_o = 0 and no grants; a pop in the same cycle does not unblock that cycle.
- Response routing:
  - x_rvalid_o = data_rvalid_i && fifo not empty && (head == x).
  - Both rdata outputs = data_rdata_i, unqualified.
  - Responses arrive in grant order; there is no reordering.
- rvalid with an empty FIFO:
  - Set err_o (cleared only by reset).
  - Assert no rvalid output and do not change the count.
- Reset mid-operation: FIFO and FSM are cleared immediately; responses still in flight after reset raise err_o.
- outstanding_o is the registered FIFO count; pointers wrap modulo MAX_OUT.

Decomposition:
- accelerator_pkg gets:
  - typedef enum logic {ARB_CORE, ARB_VLSU} arb_id_t
  - typedef enum logic {ARB_FREE, ARB_HOLD} arb_state_t
- One sub-module, arb_id_fifo:
  - Parameterised depth; 1-bit arb_id_t entries.
  - Ports: push, pop, din, head, full, empty, count.

Test Plan:
1. Core only, addr 0x100, rvalid 2 cycles after gnt -> core_gnt_o in the same cycle as data_gnt_i; core_rvalid_o in the rvalid cycle with rdata 0xDEADBEEF; vlsu_rvalid_o stays 0.
2. Both request, memory grants every cycle, 4 cycles -> grants alternate core, vlsu, core, vlsu; data_addr_o follows the winner.
3. Both request with data_gnt_i low for 3 cycles, selection = vlsu -> data_addr_o stays at the vlsu address and state is ARB_HOLD; on the grant, vlsu_gnt_o = 1 and core wins next.
4. MAX_OUT=2, two grants with no rvalid -> outstanding_o = 2 and data_req_o = 0 despite a core request; after one rvalid, count = 1 and the request resumes the next cycle.
5. Interleaved core, vlsu, core grants with in-order rvalids -> rvalid goes to core, vlsu, core respectively; push and pop in the same cycle keep the count constant.
6. data_rvalid_i with the FIFO empty -> err_o = 1 and stays 1; n_reset low mid-transaction -> all outputs 0, outstanding_o = 0, err_o = 0.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared types for the OBI data-port arbiter.
// Requester ids and arbitration FSM states.
package accelerator_pkg;

  typedef enum logic {ARB_CORE, ARB_VLSU} arb_id_t;
  typedef enum logic {ARB_FREE, ARB_HOLD} arb_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester ids for granted transactions.
// Head names the owner of the next memory response.
module arb_id_fifo
  import accelerator_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          push,
  input  logic          pop,
  input  arb_id_t       din,
  output arb_id_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);

  arb_id_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ARB_CORE;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PMAX) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PMAX) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/obi_data_arbiter.sv
// Round-robin arbiter sharing one OBI data port between core LSU
// and vector LSU, routing responses back in grant order.
module obi_data_arbiter
  import accelerator_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int ADDR_W  = 32,
  parameter int CW      = $clog2(MAX_OUT) + 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [31:0]       core_wdata_i,
  output logic [31:0]       core_rdata_o,
  input  logic              vlsu_req_i,
  output logic              vlsu_gnt_o,
  output logic              vlsu_rvalid_o,
  input  logic [ADDR_W-1:0] vlsu_addr_i,
  input  logic              vlsu_we_i,
  input  logic [3:0]        vlsu_be_i,
  input  logic [31:0]       vlsu_wdata_i,
  output logic [31:0]       vlsu_rdata_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i,
  output logic [CW-1:0]     outstanding_o,
  output logic              err_o
);

  arb_state_t state;
  arb_id_t    hold_id;
  arb_id_t    last_grant;
  arb_id_t    sel;
  arb_id_t    head;
  logic       sel_req;
  logic       granted;
  logic       fifo_full;
  logic       fifo_empty;
  logic       rsp_ok;

  always_comb begin
    if (state == ARB_HOLD) begin
      sel = hold_id;
    end else if (core_req_i && vlsu_req_i) begin
      sel = (last_grant == ARB_VLSU) ? ARB_CORE : ARB_VLSU;
    end else if (vlsu_req_i) begin
      sel = ARB_VLSU;
    end else begin
      sel = ARB_CORE;
    end
  end

  assign sel_req    = (sel == ARB_VLSU) ? vlsu_req_i : core_req_i;
  assign data_req_o = sel_req && !fifo_full;
  assign granted    = data_req_o && data_gnt_i;
  assign core_gnt_o = granted && (sel == ARB_CORE);
  assign vlsu_gnt_o = granted && (sel == ARB_VLSU);

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      if (sel == ARB_VLSU) begin
        data_addr_o  = vlsu_addr_i;
        data_we_o    = vlsu_we_i;
        data_be_o    = vlsu_be_i;
        data_wdata_o = vlsu_wdata_i;
      end else begin
        data_addr_o  = core_addr_i;
        data_we_o    = core_we_i;
        data_be_o    = core_be_i;
        data_wdata_o = core_wdata_i;
      end
    end
  end

  assign rsp_ok        = data_rvalid_i && !fifo_empty;
  assign core_rvalid_o = rsp_ok && (head == ARB_CORE);
  assign vlsu_rvalid_o = rsp_ok && (head == ARB_VLSU);
  assign core_rdata_o  = data_rdata_i;
  assign vlsu_rdata_o  = data_rdata_i;

  // Selection is frozen once offered to memory until it is granted.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= ARB_FREE;
      hold_id    <= ARB_CORE;
      last_grant <= ARB_VLSU;
      err_o      <= 1'b0;
    end else begin
      if (data_rvalid_i && fifo_empty) begin
        err_o <= 1'b1;
      end
      unique case (state)
        ARB_FREE: begin
          if (granted) begin
            last_grant <= sel;
          end else if (data_req_o) begin
            hold_id <= sel;
            state   <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (granted) begin
            last_grant <= sel;
            state      <= ARB_FREE;
          end else if (!sel_req) begin
            state <= ARB_FREE;
          end
        end
        default: state <= ARB_FREE;
      endcase
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUT),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (granted),
    .pop     (data_rvalid_i),
    .din     (sel),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o)
  );

endmodule
